// File: rtl/psx_poller.sv
// Console-side master for the PSX controller serial link: issues one 5-byte poll per start
// request and returns the controller ID and the 16 raw active-low button bits.
module psx_poller #(
   parameter int CLK_DIV     = 8,
   parameter int ATT_SETUP   = 16,
   parameter int ACK_TIMEOUT = 256,
   parameter int BYTE_GAP    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        data,
   input  logic        ack,
   output logic        psx_clk,
   output logic        cmd,
   output logic        att,
   output logic        busy,
   output logic        done,
   output logic [7:0]  id,
   output logic [15:0] buttons,
   output logic        timeout_err,
   output logic        header_err
);

   typedef enum logic [2:0] {IDLE, SETUP, CLK_LO, CLK_HI, ACK_WAIT, GAP, FINISH} state_t;

   localparam logic [15:0] SETUP_END = 16'(ATT_SETUP - 1);
   localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
   localparam logic [15:0] ACK_END   = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0] GAP_END   = 16'(BYTE_GAP - 1);

   state_t      state_r, state_nxt_s;
   logic [15:0] cnt_r;
   logic [2:0]  byte_idx_r, bit_idx_r;
   logic [7:0]  rx_r, resp1_r, resp2_r, resp3_r, resp4_r;
   logic        data_meta_r, data_sync_r, ack_meta_r, ack_sync_r;

   function automatic logic cmd_bit(input logic [2:0] byte_sel, input logic [2:0] bit_sel);
      logic [7:0] b;
      case (byte_sel)
         3'd0:    b = 8'h01;
         3'd1:    b = 8'h42;
         default: b = 8'h00;
      endcase
      return b[bit_sel];
   endfunction

   // Two-stage synchronizers for the controller's data and ack lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
         ack_meta_r  <= 1'b1;
         ack_sync_r  <= 1'b1;
      end else begin
         data_meta_r <= data;
         data_sync_r <= data_meta_r;
         ack_meta_r  <= ack;
         ack_sync_r  <= ack_meta_r;
      end
   end

   // Next-state logic; a start during the done cycle is deliberately not accepted.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:     if (start && !done) state_nxt_s = SETUP; else state_nxt_s = IDLE;
         SETUP:    if (cnt_r == SETUP_END) state_nxt_s = CLK_LO; else state_nxt_s = SETUP;
         CLK_LO:   if (cnt_r == DIV_END) state_nxt_s = CLK_HI; else state_nxt_s = CLK_LO;
         CLK_HI: begin
            if (cnt_r == DIV_END) begin
               if (bit_idx_r != 3'd7)      state_nxt_s = CLK_LO;
               else if (byte_idx_r < 3'd4) state_nxt_s = ACK_WAIT;
               else                        state_nxt_s = FINISH;
            end else begin
               state_nxt_s = CLK_HI;
            end
         end
         ACK_WAIT: begin
            if (!ack_sync_r)            state_nxt_s = GAP;
            else if (cnt_r == ACK_END)  state_nxt_s = FINISH;
            else                        state_nxt_s = ACK_WAIT;
         end
         GAP:      if (cnt_r == GAP_END) state_nxt_s = CLK_LO; else state_nxt_s = GAP;
         FINISH:   state_nxt_s = IDLE;
         default:  state_nxt_s = IDLE;
      endcase
   end

   // State register plus the link/datapath actions taken on each transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 16'd0;
         byte_idx_r  <= 3'd0;
         bit_idx_r   <= 3'd0;
         rx_r        <= 8'hFF;
         resp1_r     <= 8'hFF;
         resp2_r     <= 8'hFF;
         resp3_r     <= 8'hFF;
         resp4_r     <= 8'hFF;
         psx_clk     <= 1'b1;
         cmd         <= 1'b1;
         att         <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         id          <= 8'hFF;
         buttons     <= 16'hFFFF;
         timeout_err <= 1'b0;
         header_err  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= (state_nxt_s != state_r) ? 16'd0 : cnt_r + 16'd1;
         done    <= 1'b0;
         case (state_r)
            IDLE: if (state_nxt_s == SETUP) begin
               att         <= 1'b0;
               busy        <= 1'b1;
               timeout_err <= 1'b0;
               header_err  <= 1'b0;
               byte_idx_r  <= 3'd0;
               bit_idx_r   <= 3'd0;
            end
            SETUP: if (state_nxt_s == CLK_LO) begin
               psx_clk <= 1'b0;
               cmd     <= cmd_bit(byte_idx_r, bit_idx_r);
            end
            CLK_LO: if (state_nxt_s == CLK_HI) begin
               psx_clk <= 1'b1;
               rx_r    <= {data_sync_r, rx_r[7:1]};
            end
            CLK_HI: if (state_nxt_s == CLK_LO) begin
               bit_idx_r <= bit_idx_r + 3'd1;
               psx_clk   <= 1'b0;
               cmd       <= cmd_bit(byte_idx_r, bit_idx_r + 3'd1);
            end else if (state_nxt_s != CLK_HI) begin
               cmd <= 1'b1;
               case (byte_idx_r)
                  3'd1:    resp1_r <= rx_r;
                  3'd2:    resp2_r <= rx_r;
                  3'd3:    resp3_r <= rx_r;
                  3'd4:    resp4_r <= rx_r;
                  default: ;
               endcase
            end
            ACK_WAIT: if (state_nxt_s == FINISH) timeout_err <= 1'b1;
            GAP: if (state_nxt_s == CLK_LO) begin
               byte_idx_r <= byte_idx_r + 3'd1;
               bit_idx_r  <= 3'd0;
               psx_clk    <= 1'b0;
               cmd        <= cmd_bit(byte_idx_r + 3'd1, 3'd0);
            end
            FINISH: begin
               att     <= 1'b1;
               psx_clk <= 1'b1;
               cmd     <= 1'b1;
               done    <= 1'b1;
               busy    <= 1'b0;
               // Only a poll that reached byte 4 may touch the result registers.
               if (byte_idx_r == 3'd4) begin
                  if (resp2_r != 8'h5A) begin
                     header_err <= 1'b1;
                  end else begin
                     id      <= resp1_r;
                     buttons <= {resp4_r, resp3_r};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_psx_poller.sv
// Directed bench for psx_poller with a behavioural PSX controller answering on the link.
module tb_psx_poller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        data = 1'b1;
   logic        ack = 1'b1;
   logic        psx_clk, cmd, att, busy, done;
   logic [7:0]  id;
   logic [15:0] buttons;
   logic        timeout_err, header_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Controller model state
   logic [7:0] rsp    [0:4];
   logic [7:0] cmd_rx [0:4];
   logic       ack_en = 1'b1;
   logic       psx_prev = 1'b1;
   int         m_byte = 0;
   int         m_bit = 0;
   int         ack_cd = 0;
   int         falls = 0;
   int         done_cnt = 0;

   psx_poller dut (
      .clk(clk), .rst(rst), .start(start), .data(data), .ack(ack),
      .psx_clk(psx_clk), .cmd(cmd), .att(att), .busy(busy), .done(done),
      .id(id), .buttons(buttons), .timeout_err(timeout_err), .header_err(header_err)
   );

   always #5 clk = ~clk;

   // Controller: data changes after psx_clk falls, cmd captured on the rise, ack pulsed after bytes 0-3.
   always @(negedge clk) begin
      if (att) begin
         m_byte = 0; m_bit = 0; data = 1'b1; ack = 1'b1; ack_cd = 0;
      end else begin
         if (ack_cd != 0) ack_cd--;
         ack = !(ack_cd != 0 && ack_cd <= 6);
         if (psx_prev && !psx_clk) begin
            falls++;
            if (m_byte < 5) data = rsp[m_byte][m_bit];
         end
         if (!psx_prev && psx_clk && m_byte < 5) begin
            cmd_rx[m_byte][m_bit] = cmd;
            if (m_bit == 7) begin
               m_bit = 0;
               if (m_byte < 4 && ack_en) ack_cd = 16;
               m_byte++;
            end else begin
               m_bit++;
            end
         end
      end
      psx_prev = psx_clk;
   end

   always @(negedge clk) if (done) done_cnt++;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_rsp(input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
      rsp[0] = 8'hFF; rsp[1] = b1; rsp[2] = b2; rsp[3] = b3; rsp[4] = b4;
   endtask

   // Pulse start, wait (bounded) for done; optionally fire extra starts mid-poll and on the done cycle.
   task automatic run_poll(input bit extra, output int cyc);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      check_val("busy_after_start", busy, 1);
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         start = (extra && cyc == 200) ? 1'b1 : 1'b0;
      end
      check_val("poll_done", done, 1);
      start = extra;
      @(negedge clk);
      start = 1'b0;
      check_val("done_one_cycle", done, 0);
   endtask

   initial begin
      int cyc;
      int f0;
      int d0;
      set_rsp(8'h41, 8'h5A, 8'hFE, 8'hFD);
      repeat (3) @(negedge clk);
      check_val("rst_psx_clk", psx_clk, 1);
      check_val("rst_cmd", cmd, 1);
      check_val("rst_att", att, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_id", id, 8'hFF);
      check_val("rst_buttons", buttons, 16'hFFFF);
      check_val("rst_tmo", timeout_err, 0);
      check_val("rst_hdr", header_err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ack never answers: abort after byte 0 plus the ack timeout
      ack_en = 1'b0;
      f0 = falls;
      run_poll(1'b0, cyc);
      check_val("tmo_latency", (cyc >= 400 && cyc <= 404), 1);
      check_val("tmo_flag", timeout_err, 1);
      check_val("tmo_hdr", header_err, 0);
      check_val("tmo_att", att, 1);
      check_val("tmo_buttons", buttons, 16'hFFFF);
      check_val("tmo_id", id, 8'hFF);
      check_val("tmo_falls", falls - f0, 8);

      // normal poll with ignored starts mid-poll and on the done cycle
      ack_en = 1'b1;
      f0 = falls;
      run_poll(1'b1, cyc);
      check_val("ok_tmo_cleared", timeout_err, 0);
      check_val("ok_hdr", header_err, 0);
      check_val("ok_id", id, 8'h41);
      check_val("ok_buttons", buttons, 16'hFDFE);
      check_val("ok_att", att, 1);
      check_val("ok_cmd_stream", {cmd_rx[0], cmd_rx[1], cmd_rx[2], cmd_rx[3], cmd_rx[4]},
                40'h0142000000);
      check_val("ok_falls", falls - f0, 40);
      repeat (40) @(negedge clk);
      check_val("extra_start_busy", busy, 0);
      check_val("extra_start_att", att, 1);
      check_val("extra_start_falls", falls - f0, 40);

      // bad header byte: flag set, results keep previous values
      set_rsp(8'h73, 8'h00, 8'h12, 8'h34);
      run_poll(1'b0, cyc);
      check_val("hdr_flag", header_err, 1);
      check_val("hdr_tmo", timeout_err, 0);
      check_val("hdr_id_kept", id, 8'h41);
      check_val("hdr_buttons_kept", buttons, 16'hFDFE);

      // reset in the middle of byte 2
      set_rsp(8'h41, 8'h5A, 8'hFE, 8'hFD);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!(m_byte == 2 && psx_clk == 1'b0) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check_val("mid_byte2_reached", (m_byte == 2 && psx_clk == 1'b0), 1);
      check_val("mid_cmd_low", cmd, 0);
      d0 = done_cnt;
      #1 rst = 1'b1;
      #1;
      check_val("arst_psx_clk", psx_clk, 1);
      check_val("arst_cmd", cmd, 1);
      check_val("arst_att", att, 1);
      check_val("arst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_val("arst_no_done", done_cnt - d0, 0);

      // clean poll after the reset
      f0 = falls;
      run_poll(1'b0, cyc);
      check_val("post_id", id, 8'h41);
      check_val("post_buttons", buttons, 16'hFDFE);
      check_val("post_errs", {timeout_err, header_err}, 2'b00);
      check_val("post_cmd_stream", {cmd_rx[0], cmd_rx[1], cmd_rx[2], cmd_rx[3], cmd_rx[4]},
                40'h0142000000);
      check_val("post_falls", falls - f0, 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psx_poller.md
Name: psx_poller

Overview:
- Host-side (console-role) master for the PSX controller serial link; sits directly upstream of the controller model and drives its psx_clk, cmd and att inputs, consuming its data and ack outputs.
- On each start request, performs one standard 5-byte poll (0x01, 0x42, 0x00, 0x00, 0x00) and returns the controller ID and the 16 active-low button bits to the core logic.
- Fully synchronous to clk; the serial link clock is generated by division.

Parameters:
- CLK_DIV, 8, clk cycles per psx_clk half-period (minimum 4).
- ATT_SETUP, 16, clk cycles from att falling to the first psx_clk falling edge.
- ACK_TIMEOUT, 256, clk cycles to wait for an ack low after bytes 0-3 before aborting.
- BYTE_GAP, 8, clk cycles between ack detection and the next byte's first psx_clk fall.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle poll request; ignored while busy
- data  in  1  serial data from controller, sampled via a 2-FF synchronizer
- ack  in  1  active-low acknowledge from controller, sampled via a 2-FF synchronizer
- psx_clk  out  1  link clock, idle high
- cmd  out  1  serial command, LSB first, idle high
- att  out  1  active-low select
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle pulse when a poll completes (success or error)
- id  out  8  byte 1 of the response, updated on successful completion
- buttons  out  16  {byte4, byte3} of the response, raw active-low, updated on success only
- timeout_err  out  1  sticky; set on ack timeout, cleared by the next accepted start
- header_err  out  1  sticky; set when byte 2 != 8'h5A, cleared by the next accepted start

Behaviour:
- Reset (async, active-high):
  - psx_clk=1, cmd=1, att=1, busy=0, done=0.
  - id=8'hFF, buttons=16'hFFFF, timeout_err=0, header_err=0.
  - FSM=IDLE; synchronizers preset to 1.
- Reset mid-poll immediately returns all link outputs to idle-high; no done pulse is generated.
- FSM states: IDLE, SETUP, CLK_LO, CLK_HI, ACK_WAIT, GAP, FINISH.
- IDLE:
  - start=1 -> clear both error flags, load byte_idx=0, att<=0, busy<=1, go to SETUP.
  - start while busy is ignored.
- SETUP: count ATT_SETUP cycles -> CLK_LO with bit_idx=0.
- CLK_LO:
  - On entry, psx_clk<=0 and cmd<=cmd_byte[byte_idx][bit_idx].
  - Hold for CLK_DIV cycles, then go to CLK_HI.
- CLK_HI:
  - On entry, psx_clk<=1 and the synchronized data is shifted into rx[7] (right shift, LSB-first assembly).
  - Hold for CLK_DIV cycles.
  - If bit_idx<7, increment bit_idx -> CLK_LO.
  - Otherwise store rx into resp[byte_idx] and set cmd<=1.
  - Then go to ACK_WAIT if byte_idx<4, else to FINISH.
- Command bytes: byte 0 = 8'h01, byte 1 = 8'h42, bytes 2-4 = 8'h00.
- ACK_WAIT:
  - The counter starts at 0 on entry.
  - Synchronized ack==0 -> GAP.
  - Counter reaches ACK_TIMEOUT -> set timeout_err, go to FINISH.
  - An ack low pulse arriving before ACK_WAIT (i.e. during a byte) is ignored.
  - An ack still low from the previous byte is not double-counted, because GAP enforces separation.
- GAP: count BYTE_GAP cycles, increment byte_idx, bit_idx=0 -> CLK_LO.
- FINISH:
  - att<=1, psx_clk=1, cmd=1.
  - If byte 4 completed and resp[2]!=8'h5A, set header_err.
  - If byte 4 completed and resp[2]==8'h5A, id<=resp[1] and buttons<={resp[4],resp[3]}.
  - done pulses one cycle, busy<=0 -> IDLE.
  - On a timeout abort, id and buttons keep their previous values.
- A start asserted in the same cycle as the done pulse is ignored; a start in the next cycle is accepted.
- Poll latency with ack responding immediately:
  - ATT_SETUP + 5*16*CLK_DIV + 4*(ack latency + 2 sync + BYTE_GAP) + 1 cycles.

Test Plan:
- Fake controller default response (ID 0x41, 0x5A, data1 8'hFE, data2 8'hFD), CLK_DIV=8, start pulse -> after one poll: done=1 for 1 cycle, id=8'h41, buttons=16'hFDFE, both error flags 0, att back to 1.
- Monitor cmd on each psx_clk rising edge during the poll -> observed bit stream decodes LSB-first to 01 42 00 00 00; exactly 40 psx_clk falling edges occur while att=0.
- ack tied high -> after byte 0 plus ACK_TIMEOUT cycles: timeout_err=1, done pulse, att=1, buttons stays 16'hFFFF; the next start clears timeout_err.
- Controller returns 8'h00 as byte 2 -> header_err=1, buttons and id unchanged from the previous successful poll.
- Assert rst during byte 2 -> psx_clk, cmd and att all 1 asynchronously, busy=0, no done; a subsequent start performs a clean full poll.
- Assert start again while busy and on the done cycle -> both ignored; exactly one poll's worth of att-low activity occurs.
